regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the 16x16 two-read/one-write register file.
- Generalised in data width and depth.
- Adds an asynchronous active-low reset, an optional hardwired-zero register 0, optional same-cycle write-to-read bypass, and a per-register pending-write scoreboard.
- Sits in the ID stage of the pipelined computer: reads operands, flags operands whose producer has not yet written back, and receives WB-stage writes.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; depth = 2**ADDR_W registers
ZERO_R0, 1, 1 = register 0 always reads 0, ignores writes, never pending
BYPASS, 1, 1 = a write in the current cycle is forwarded to a matching read port in the same cycle

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
addr_r1  input  ADDR_W  read port 1 address
addr_r2  input  ADDR_W  read port 2 address
data_r1  output  DATA_W  read port 1 data (combinational)
data_r2  output  DATA_W  read port 2 data (combinational)
busy_r1  output  1  register at addr_r1 has a pending write
busy_r2  output  1  register at addr_r2 has a pending write
write_en  input  1  WB write strobe
addr_w  input  ADDR_W  WB write address
data_w  input  DATA_W  WB write data
iss_en  input  1  issue strobe: mark addr_iss pending
addr_iss  input  ADDR_W  destination register of issuing instruction
pend_cnt  output  ADDR_W+1  number of registers currently pending (registered)

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-operation):
  - All registers clear to 0, all pending bits clear to 0, pend_cnt=0.
  - While rst_n=0, data_r1/2 read 0 and busy_r1/2 read 0, regardless of write_en/iss_en.
- Write: on posedge clk with write_en=1, reg[addr_w] <= data_w and pending[addr_w] <= 0.
  - Exception: iss_en=1 with addr_iss==addr_w in the same cycle leaves the pending bit set, because a new producer supersedes the old one.
- Issue: on posedge clk with iss_en=1, pending[addr_iss] <= 1. Issuing an already-pending register leaves it pending and does not change pend_cnt.
- ZERO_R0=1:
  - Writes to address 0 are dropped.
  - Issue to address 0 is ignored.
  - Reads of address 0 return 0 with busy=0, bypass included.
- ZERO_R0=0: register 0 is an ordinary register.
- Read, no bypass match: data_rN = reg[addr_rN], busy_rN = pending[addr_rN]; zero-cycle latency.
- Read with BYPASS=1, write_en=1 and addr_w==addr_rN (and not the zeroed R0):
  - data_rN = data_w, busy_rN = 0.
  - An issue in the same cycle does not affect busy until the next cycle.
- Read with BYPASS=0: data_rN shows the old value until after the edge; busy_rN shows the current pending bit.
- Both read ports may address the same register; they return identical data/busy.
- pend_cnt:
  - Registered population count of pending bits, updated on the same edge as the bits.
  - Never exceeds 2**ADDR_W (or 2**ADDR_W-1 with ZERO_R0=1).
  - Net change per cycle is -1, 0 or +1.
- Writes to a non-pending register are legal: data updates, pending stays 0, pend_cnt unchanged.
- No X propagation: addresses are always in range by construction, since depth = 2**ADDR_W.

Test Plan:
- Reset: drive write_en=1 addr_w=3 data_w=16'h0100, pulse rst_n low mid-cycle -> all reads 0, busy 0, pend_cnt 0 immediately and after release; reg 3 reads 0.
- Write/read with the read data fed back as new write data: write reg1=16'h0100, then read r1=r2=1 -> both 16'h0100; write data_r1-data_r2 to reg1 next edge -> reg1 reads 16'h0000.
- Bypass: BYPASS=1, reg5=16'h1111, write_en=1 addr_w=5 data_w=16'hABCD, addr_r1=5 -> data_r1=16'hABCD in the same cycle. With BYPASS=0 -> 16'h1111 until the edge.
- Scoreboard: iss_en addr_iss=7 -> next cycle busy_r1=1 for addr_r1=7, pend_cnt=1. Write reg7=16'h0042 -> busy_r1=0, pend_cnt=0, data 16'h0042. Same-cycle iss+write on 7 -> busy stays 1, pend_cnt=1.
- R0: ZERO_R0=1, write 16'hFFFF to addr 0 and iss_en addr_iss=0 -> data_r1=0, busy_r1=0, pend_cnt unchanged. ZERO_R0=0 -> reads 16'hFFFF.
- Width/depth: DATA_W=32, ADDR_W=5, issue all 31 non-zero registers -> pend_cnt=31. Write each back in turn -> pend_cnt decrements to 0, data 32'hDEAD_0000+i read back correctly.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parameterised 2R/1W register file for the ID stage, with a
// per-register pending-write scoreboard.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   addr_r1/addr_r2     read addresses; data_rN/busy_rN are combinational
//   write_en/addr_w/data_w  WB-stage write (clears the pending bit)
//   iss_en/addr_iss     issue: marks the destination register pending
//   pend_cnt            registered count of pending registers
//
// Parameters: DATA_W, ADDR_W (depth = 2**ADDR_W), ZERO_R0 (hardwired-zero
// register 0), BYPASS (same-cycle write-to-read forwarding).
module regfile_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_r1,
  input  logic [ADDR_W-1:0] addr_r2,
  output logic [DATA_W-1:0] data_r1,
  output logic [DATA_W-1:0] data_r2,
  output logic              busy_r1,
  output logic              busy_r2,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [DATA_W-1:0] data_w,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] addr_iss,
  output logic [ADDR_W:0]   pend_cnt
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]             pend_q, pend_d;
  logic [ADDR_W:0]              cnt_q, cnt_d;

  // Accesses to the hardwired-zero register are dropped at the source, so
  // register 0 never changes and never becomes pending.
  logic wr_ok, iss_ok;
  assign wr_ok  = write_en && !((ZERO_R0 != 0) && (addr_w   == '0));
  assign iss_ok = iss_en   && !((ZERO_R0 != 0) && (addr_iss == '0));

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_ok) begin
      regs_d[addr_w] = data_w;
      pend_d[addr_w] = 1'b0;
    end
    // Issue is applied after the write so a same-cycle re-issue of the
    // register being written back keeps it pending (new producer wins).
    if (iss_ok) pend_d[addr_iss] = 1'b1;
  end

  // Count is derived from the next pending vector, so it always matches the
  // bits it describes on the same edge.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

  // Read path: {busy, data}. Outputs are forced quiet while in reset because
  // the bypass path would otherwise leak data_w combinationally.
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] r;
    r = {pend_q[a], regs_q[a]};
    if ((BYPASS != 0) && write_en && (addr_w == a)) r = {1'b0, data_w};
    if (((ZERO_R0 != 0) && (a == '0)) || !rst_n)   r = '0;
    return r;
  endfunction

  assign {busy_r1, data_r1} = read_port(addr_r1);
  assign {busy_r2, data_r2} = read_port(addr_r2);

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus for two 16x16 instances: u0 (ZERO_R0=1,BYPASS=1) and
  // u1 (ZERO_R0=0,BYPASS=0).
  logic [3:0]  ar1, ar2, aw, ai;
  logic [15:0] dw;
  logic        we, ie;
  logic [15:0] d0_r1, d0_r2, d1_r1, d1_r2;
  logic        b0_r1, b0_r2, b1_r1, b1_r2;
  logic [4:0]  c0, c1;

  // 32-bit x 32-entry instance
  logic [4:0]  ar1_w, ar2_w, aw_w, ai_w;
  logic [31:0] dw_w, d2_r1, d2_r2;
  logic        we_w, ie_w, b2_r1, b2_r2;
  logic [5:0]  c2;

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1), .BYPASS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .addr_r1(ar1), .addr_r2(ar2),
    .data_r1(d0_r1), .data_r2(d0_r2), .busy_r1(b0_r1), .busy_r2(b0_r2),
    .write_en(we), .addr_w(aw), .data_w(dw), .iss_en(ie), .addr_iss(ai),
    .pend_cnt(c0));

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(0), .BYPASS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .addr_r1(ar1), .addr_r2(ar2),
    .data_r1(d1_r1), .data_r2(d1_r2), .busy_r1(b1_r1), .busy_r2(b1_r2),
    .write_en(we), .addr_w(aw), .data_w(dw), .iss_en(ie), .addr_iss(ai),
    .pend_cnt(c1));

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1), .BYPASS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .addr_r1(ar1_w), .addr_r2(ar2_w),
    .data_r1(d2_r1), .data_r2(d2_r2), .busy_r1(b2_r1), .busy_r2(b2_r2),
    .write_en(we_w), .addr_w(aw_w), .data_w(dw_w), .iss_en(ie_w),
    .addr_iss(ai_w), .pend_cnt(c2));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model for u0/u1 ----------------
  logic [15:0] m_reg  [2][16];
  logic        m_pend [2][16];
  int          m_zero [2] = '{1, 0};
  int          m_byp  [2] = '{1, 0};

  task automatic m_reset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 16; r++) begin
        m_reg[k][r]  = '0;
        m_pend[k][r] = 1'b0;
      end
  endtask

  // Architectural effect of one clock edge with the current inputs.
  task automatic m_edge();
    for (int k = 0; k < 2; k++) begin
      if (we && !(m_zero[k] != 0 && aw == 0)) begin
        m_reg[k][aw]  = dw;
        m_pend[k][aw] = 1'b0;
      end
      if (ie && !(m_zero[k] != 0 && ai == 0)) m_pend[k][ai] = 1'b1;
    end
  endtask

  function automatic logic [16:0] m_read(input int k, input logic [3:0] a);
    if (!rst_n) return '0;
    if (m_zero[k] != 0 && a == 0) return '0;
    if (m_byp[k] != 0 && we && aw == a) return {1'b0, dw};
    return {m_pend[k][a], m_reg[k][a]};
  endfunction

  function automatic logic [4:0] m_cnt(input int k);
    logic [4:0] n = '0;
    for (int r = 0; r < 16; r++) n += {4'd0, m_pend[k][r]};
    return n;
  endfunction

  task automatic model_check();
    logic [16:0] e;
    e = m_read(0, ar1); chk("u0_r1", {b0_r1, d0_r1}, e);
    e = m_read(0, ar2); chk("u0_r2", {b0_r2, d0_r2}, e);
    e = m_read(1, ar1); chk("u1_r1", {b1_r1, d1_r1}, e);
    e = m_read(1, ar2); chk("u1_r2", {b1_r2, d1_r2}, e);
    chk("u0_cnt", c0, m_cnt(0));
    chk("u1_cnt", c1, m_cnt(1));
  endtask

  // Apply one clock edge (inputs already driven after a negedge).
  task automatic step();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [3:0]  aw;
    logic [15:0] dw;
    logic        ie;
    logic [3:0]  ai;
    logic [3:0]  ar;
    logic [15:0] e0_d;   // u0 data_r1 before the edge
    logic        e0_b;   // u0 busy_r1 before the edge
    logic [15:0] e1_d;   // u1 data_r1 before the edge
    logic [4:0]  e0_c;   // u0 pend_cnt before the edge
  } vec_t;
  vec_t tbl[13];

  initial begin
    logic [15:0] fb;
    tbl[0]  = '{1'b1, 4'd1, 16'h0100, 1'b0, 4'd0, 4'd1, 16'h0100, 1'b0, 16'h0000, 5'd0};
    tbl[1]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd1, 16'h0100, 1'b0, 16'h0100, 5'd0};
    tbl[2]  = '{1'b1, 4'd5, 16'h1111, 1'b0, 4'd0, 4'd5, 16'h1111, 1'b0, 16'h0000, 5'd0};
    tbl[3]  = '{1'b1, 4'd5, 16'hABCD, 1'b0, 4'd0, 4'd5, 16'hABCD, 1'b0, 16'h1111, 5'd0};
    tbl[4]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd5, 16'hABCD, 1'b0, 16'hABCD, 5'd0};
    tbl[5]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd7, 16'h0000, 1'b0, 16'h0000, 5'd0};
    tbl[6]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd7, 16'h0000, 1'b1, 16'h0000, 5'd1};
    tbl[7]  = '{1'b1, 4'd7, 16'h0042, 1'b0, 4'd0, 4'd7, 16'h0042, 1'b0, 16'h0000, 5'd1};
    tbl[8]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd7, 16'h0042, 1'b0, 16'h0042, 5'd0};
    tbl[9]  = '{1'b1, 4'd7, 16'h0099, 1'b1, 4'd7, 4'd7, 16'h0099, 1'b0, 16'h0042, 5'd0};
    tbl[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd7, 16'h0099, 1'b1, 16'h0099, 5'd1};
    tbl[11] = '{1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 4'd0, 16'h0000, 1'b0, 16'h0000, 5'd1};
    tbl[12] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 16'h0000, 1'b0, 16'hFFFF, 5'd1};

    // reset with activity on the inputs
    rst_n = 1'b0;
    we = 1'b1; aw = 4'd3; dw = 16'h0100; ie = 1'b1; ai = 4'd3;
    ar1 = 4'd3; ar2 = 4'd3;
    we_w = 1'b0; aw_w = '0; dw_w = '0; ie_w = 1'b0; ai_w = '0; ar1_w = '0; ar2_w = '0;
    m_reset();
    repeat (2) @(negedge clk);
    model_check();
    chk("rst_u2_cnt", c2, 6'd0);
    rst_n = 1'b1;
    we = 1'b0; ie = 1'b0;
    #1 model_check();

    // directed table
    foreach (tbl[i]) begin
      we = tbl[i].we; aw = tbl[i].aw; dw = tbl[i].dw;
      ie = tbl[i].ie; ai = tbl[i].ai; ar1 = tbl[i].ar; ar2 = tbl[i].ar;
      #1;
      chk($sformatf("tbl%0d_u0_d", i), d0_r1, tbl[i].e0_d);
      chk($sformatf("tbl%0d_u0_b", i), b0_r1, tbl[i].e0_b);
      chk($sformatf("tbl%0d_u1_d", i), d1_r1, tbl[i].e1_d);
      chk($sformatf("tbl%0d_u0_c", i), c0, tbl[i].e0_c);
      model_check();
      step();
    end

    // read data fed back as write data: reg1 <= data_r1 - data_r2
    we = 1'b0; ie = 1'b0; ar1 = 4'd1; ar2 = 4'd1;
    #1;
    chk("fb_r1", d0_r1, 16'h0100);
    chk("fb_r2", d0_r2, 16'h0100);
    fb = d0_r1 - d0_r2;
    we = 1'b1; aw = 4'd1; dw = fb;
    #1 model_check();
    step();
    we = 1'b0;
    #1;
    chk("fb_after", d0_r1, 16'h0000);
    model_check();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 2) == 0);
      aw = 4'($urandom_range(0, 15));
      ai = 4'($urandom_range(0, 15));
      dw = 16'($urandom);
      ar1 = ($urandom_range(0, 2) == 0) ? aw : 4'($urandom_range(0, 15));
      ar2 = ($urandom_range(0, 3) == 0) ? ar1 : 4'($urandom_range(0, 15));
      #1 model_check();
      step();
    end

    // mid-cycle reset with an issue and write in flight
    we = 1'b1; aw = 4'd3; dw = 16'h0100; ie = 1'b1; ai = 4'd9;
    ar1 = 4'd3; ar2 = 4'd9;
    #1 model_check();
    #1 rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_mid_d", d0_r1, 16'h0000);
    chk("rst_mid_c0", c0, 5'd0);
    chk("rst_mid_c1", c1, 5'd0);
    model_check();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; we = 1'b0; ie = 1'b0;
    #1;
    chk("rst_rel_r3", d0_r1, 16'h0000);
    model_check();

    // 32x32 instance: fill and drain the scoreboard
    for (int i = 1; i < 32; i++) begin
      ie_w = 1'b1; ai_w = 5'(i);
      @(posedge clk); @(negedge clk);
      chk($sformatf("u2_iss_cnt%0d", i), c2, 6'(i));
    end
    // issue + write to r0 are ignored
    ie_w = 1'b1; ai_w = 5'd0; we_w = 1'b1; aw_w = 5'd0; dw_w = 32'hFFFF_FFFF; ar1_w = 5'd0;
    #1;
    chk("u2_r0_byp", {b2_r1, d2_r1}, 33'd0);
    @(posedge clk); @(negedge clk);
    ie_w = 1'b0; we_w = 1'b0;
    #1;
    chk("u2_r0_d", {b2_r1, d2_r1}, 33'd0);
    chk("u2_full_cnt", c2, 6'd31);
    for (int i = 1; i < 32; i++) begin
      int j;
      j = (i % 31) + 1;
      we_w = 1'b1; aw_w = 5'(i); dw_w = 32'hDEAD_0000 + 32'(i);
      ar1_w = 5'(i); ar2_w = 5'(j);
      #1;
      chk($sformatf("u2_byp%0d", i), {b2_r1, d2_r1}, {1'b0, 32'hDEAD_0000 + 32'(i)});
      chk($sformatf("u2_busy%0d", j), b2_r2, (j > i) ? 1'b1 : 1'b0);
      @(posedge clk); @(negedge clk);
      chk($sformatf("u2_drain_cnt%0d", i), c2, 6'(31 - i));
    end
    we_w = 1'b0;
    for (int i = 1; i < 32; i++) begin
      ar1_w = 5'(i); ar2_w = 5'(i);
      #1;
      chk($sformatf("u2_rd%0d", i), {b2_r1, d2_r1}, {1'b0, 32'hDEAD_0000 + 32'(i)});
      chk($sformatf("u2_rd2_%0d", i), d2_r2, 32'hDEAD_0000 + 32'(i));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
